gpio_control_wb_master: RTL and testbench
=========================================

// Module: gpio_control_wb_master
// PURPOSE
// - Wishbone initiator that converts one-at-a-time register commands into single Wishbone classic cycles toward the GPIO mux slave.
// - Sits between a local sequencer (e.g. boot-time pin-ownership loader) and the gpio_control slave.
// - Adds a bus timeout so a missing ack never hangs the command source.
// PARAMETERS
// - ADDR_W          32  Wishbone address width
// - DATA_W          32  Wishbone data width (multiple of 8)
// - TIMEOUT_CYCLES  16  bus cycles allowed without ack before abort; legal range 2..65535
// PORTS
// - clk_i      in   1         system clock; all logic on rising edge
// - rst_ni     in   1         reset; one clock; reset is asynchronous and active-low
// - cmd_valid  in   1         command offered
// - cmd_ready  out  1         master can accept a command
// - cmd_we     in   1         1 = write, 0 = read
// - cmd_adr    in   ADDR_W    byte address
// - cmd_dat    in   DATA_W    write data
// - cmd_sel    in   DATA_W/8  byte lane selects
// - rsp_valid  out  1         response held for source
// - rsp_ready  in   1         source consumes response
// - rsp_dat    out  DATA_W    read data (0 for writes and on error)
// - rsp_err    out  1         1 = transaction aborted by timeout
// - wbm_cyc_o, wbm_stb_o, wbm_we_o  out 1; wbm_adr_o out ADDR_W; wbm_dat_o out DATA_W; wbm_sel_o out DATA_W/8
// - wbm_ack_i  in   1;  wbm_dat_i in DATA_W
// BEHAVIOUR
// - Reset values: cmd_ready=1 (once out of reset), rsp_valid=0, rsp_err=0, rsp_dat=0, all wbm_* outputs 0; state IDLE, timer 0.
// - All outputs registered except cmd_ready = (state==IDLE).
// - States: IDLE -> BUS on cmd_valid&&cmd_ready; BUS -> RESP on ack or timeout; RESP -> IDLE on rsp_ready.
// - IDLE accept (cycle N): latch we/adr/dat/sel onto wbm_*; cyc=stb=1 from cycle N+1.
// - BUS: cyc/stb and address/data held stable until ack; ack sampled every cycle incl. first (min latency: cmd accept N, ack at N+1, rsp_valid at N+2).
// - On ack: cyc=stb=we=0 next cycle; rsp_dat=wbm_dat_i if read else 0; rsp_err=0; rsp_valid=1.
// - Timer counts cycles in BUS starting at 0; if timer==TIMEOUT_CYCLES-1 and no ack: drop cyc/stb, rsp_err=1, rsp_dat=0, rsp_valid=1.
// - Ack and final timeout cycle coincide: ack wins, rsp_err=0.
// - Ack outside BUS (stray) ignored; no effect on state or outputs.
// - RESP: rsp_* stable while rsp_valid && !rsp_ready; cmd_ready=0 so no back-to-back overlap; rsp_valid clears the cycle after rsp_ready handshake.
// - cmd_* changes while cmd_ready=0 are ignored; commands never dropped or duplicated.
// - Reset asserted mid-BUS: cyc/stb drop immediately (async), no response produced; source must reissue.
// - Timer width = clog2(TIMEOUT_CYCLES); never wraps (cleared on leaving BUS).
// STRUCTURE
// - gpio_control_pkg: state encoding (IDLE/BUS/RESP), GPIO slave register offset constants, default TIMEOUT_CYCLES.
// - One sub-module: wb_timeout_timer (clear, enable, expire output) instanced once; FSM and datapath in this file.
// TESTING
// - Write adr=0x3000_0004 dat=0xA5A5_0F0F sel=0xF, slave acks after 2 cycles -> cyc/stb high exactly 3 cycles, we=1, rsp_valid with rsp_err=0, rsp_dat=0.
// - Read adr=0x3000_0008, ack in first bus cycle with dat_i=0x0000_1234 -> rsp_valid at accept+2, rsp_dat=0x0000_1234.
// - No ack, TIMEOUT_CYCLES=16 -> cyc/stb high 16 cycles then low, rsp_err=1, rsp_dat=0; cmd_ready returns after rsp_ready.
// - Ack on cycle 16 (last timeout cycle) -> rsp_err=0, read data captured.
// - rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted until handshake.
// - rst_ni pulsed low mid-BUS -> wbm_cyc_o=0 same cycle, rsp_valid=0, cmd_ready=1 after release; stray ack then ignored.

Source files
------------

// File: rtl/gpio_control_wb_master_pkg.sv
// Shared definitions for the GPIO control Wishbone initiator: FSM encoding,
// GPIO slave register map and the default bus timeout.
package gpio_control_wb_master_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

  // Byte offsets of the gpio_control slave registers.
  localparam logic [31:0] GpioOwnerOffset = 32'h0000_0000;
  localparam logic [31:0] GpioOeOffset    = 32'h0000_0004;
  localparam logic [31:0] GpioOutOffset   = 32'h0000_0008;
  localparam logic [31:0] GpioInOffset    = 32'h0000_000C;

  localparam int unsigned DefaultTimeoutCycles = 16;

endpackage

// File: rtl/gpio_control_wb_master_if.sv
// Wishbone classic bus between the GPIO control initiator and the gpio_control slave.
interface gpio_control_wb_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  wbm_cyc_o;
  logic                  wbm_stb_o;
  logic                  wbm_we_o;
  logic [ADDR_W-1:0]     wbm_adr_o;
  logic [DATA_W-1:0]     wbm_dat_o;
  logic [DATA_W/8-1:0]   wbm_sel_o;
  logic                  wbm_ack_i;
  logic [DATA_W-1:0]     wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/gpio_control_wb_master_timer.sv
// Bus-cycle timeout counter: counts enabled cycles from zero and flags the
// last allowed cycle. Held at zero while clear is asserted, so it never wraps.
module gpio_control_wb_master_timer #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int unsigned CntW = $clog2(Cycles);
  localparam logic [CntW-1:0] Last = CntW'(Cycles - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expire_o) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == Last);

endmodule

// File: rtl/gpio_control_wb_master.sv
// Turns single register commands into Wishbone classic cycles toward the GPIO
// mux slave, returning read data or a timeout error on a held response.
module gpio_control_wb_master
  import gpio_control_wb_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [DATA_W-1:0]   cmd_dat,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_dat,
  output logic                rsp_err,
  gpio_control_wb_master_if.master wbm
);

  state_e state_q, state_d;

  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W/8-1:0] sel_q, sel_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                expire;

  gpio_control_wb_master_timer #(
    .Cycles (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q != StBus),
    .enable_i (state_q == StBus),
    .expire_o (expire)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StBus;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
        end
      end
      StBus: begin
        // Ack has priority over a timeout landing on the same cycle.
        if (wbm.wbm_ack_i) begin
          state_d     = StResp;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm.wbm_dat_i;
        end else if (expire) begin
          state_d     = StResp;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_dat       = rsp_dat_q;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = sel_q;

endmodule

// File: tb/tb_gpio_control_wb_master.sv
// Directed bench for gpio_control_wb_master: writes, reads, timeout, held
// response back-pressure and reset in the middle of a bus cycle.
module tb_gpio_control_wb_master;

  logic        clk;
  logic        rst_ni;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  gpio_control_wb_master_if wb ();

  gpio_control_wb_master dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm       (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_ni        = 1'b0;
    cmd_valid     = 1'b0;
    cmd_we        = 1'b0;
    cmd_adr       = '0;
    cmd_dat       = '0;
    cmd_sel       = '0;
    rsp_ready     = 1'b0;
    wb.wbm_ack_i  = 1'b0;
    wb.wbm_dat_i  = '0;

    tick();
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_cyc", {31'b0, wb.wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wb.wbm_stb_o}, 32'd0);
    check("rst_adr", wb.wbm_adr_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Write, slave acks in the third bus cycle.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004;
    cmd_dat = 32'hA5A5_0F0F; cmd_sel = 4'hF;
    wb.wbm_dat_i = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 1'b0;
    check("wr_cyc1", {31'b0, wb.wbm_cyc_o}, 32'd1);
    check("wr_stb1", {31'b0, wb.wbm_stb_o}, 32'd1);
    check("wr_we", {31'b0, wb.wbm_we_o}, 32'd1);
    check("wr_adr", wb.wbm_adr_o, 32'h3000_0004);
    check("wr_dat", wb.wbm_dat_o, 32'hA5A5_0F0F);
    check("wr_sel", {28'b0, wb.wbm_sel_o}, 32'hF);
    check("wr_cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
    tick();
    check("wr_cyc2", {31'b0, wb.wbm_cyc_o}, 32'd1);
    tick();
    check("wr_cyc3", {31'b0, wb.wbm_cyc_o}, 32'd1);
    wb.wbm_ack_i = 1'b1;
    tick();
    wb.wbm_ack_i = 1'b0;
    check("wr_cyc_drop", {31'b0, wb.wbm_cyc_o}, 32'd0);
    check("wr_we_drop", {31'b0, wb.wbm_we_o}, 32'd0);
    check("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("wr_rsp_dat", rsp_dat, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_rsp_clear", {31'b0, rsp_valid}, 32'd0);
    check("wr_cmd_ready_back", {31'b0, cmd_ready}, 32'd1);

    // Read, ack in the first bus cycle: response at accept+2.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0008;
    tick();
    cmd_valid = 1'b0;
    check("rd_cyc", {31'b0, wb.wbm_cyc_o}, 32'd1);
    check("rd_we", {31'b0, wb.wbm_we_o}, 32'd0);
    check("rd_adr", wb.wbm_adr_o, 32'h3000_0008);
    check("rd_rsp_not_yet", {31'b0, rsp_valid}, 32'd0);
    wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = 32'h0000_1234;
    tick();
    wb.wbm_ack_i = 1'b0;
    check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rd_rsp_dat", rsp_dat, 32'h0000_1234);
    check("rd_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rd_cyc_drop", {31'b0, wb.wbm_cyc_o}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_rsp_clear", {31'b0, rsp_valid}, 32'd0);

    // Timeout: no ack for 16 bus cycles.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (wb.wbm_cyc_o && n < 40) begin
      n++;
      tick();
    end
    check("to_cyc_cycles", n, 32'd16);
    check("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("to_rsp_err", {31'b0, rsp_err}, 32'd1);
    check("to_rsp_dat", rsp_dat, 32'd0);
    tick();
    check("to_cmd_ready_held", {31'b0, cmd_ready}, 32'd0);
    check("to_rsp_held", {31'b0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("to_rsp_clear", {31'b0, rsp_valid}, 32'd0);
    check("to_cmd_ready_back", {31'b0, cmd_ready}, 32'd1);

    // Ack on the last allowed cycle wins over the timeout.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_000C;
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    check("late_cyc16", {31'b0, wb.wbm_cyc_o}, 32'd1);
    wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = 32'hCAFE_0016;
    tick();
    wb.wbm_ack_i = 1'b0; wb.wbm_dat_i = 32'h0;
    check("late_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("late_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("late_rsp_dat", rsp_dat, 32'hCAFE_0016);

    // Response back-pressure: second command waits for the handshake.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0010;
    cmd_dat = 32'h0000_00FF; cmd_sel = 4'h3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_dat", rsp_dat, 32'hCAFE_0016);
      check("bp_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("bp_cyc", {31'b0, wb.wbm_cyc_o}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_rsp_clear", {31'b0, rsp_valid}, 32'd0);
    check("bp_cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    check("bp_not_accepted", {31'b0, wb.wbm_cyc_o}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("bp2_cyc", {31'b0, wb.wbm_cyc_o}, 32'd1);
    check("bp2_adr", wb.wbm_adr_o, 32'h3000_0010);
    check("bp2_sel", {28'b0, wb.wbm_sel_o}, 32'h3);
    wb.wbm_ack_i = 1'b1;
    tick();
    wb.wbm_ack_i = 1'b0;
    check("bp2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("bp2_rsp_dat", rsp_dat, 32'd0);
    tick();
    check("bp2_single", {31'b0, wb.wbm_cyc_o}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp2_rsp_clear", {31'b0, rsp_valid}, 32'd0);

    // Reset pulsed during a bus cycle, then a stray ack.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0004;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mr_cyc_before", {31'b0, wb.wbm_cyc_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mr_cyc_async", {31'b0, wb.wbm_cyc_o}, 32'd0);
    check("mr_stb_async", {31'b0, wb.wbm_stb_o}, 32'd0);
    check("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("mr_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = 32'hFFFF_FFFF;
    tick();
    wb.wbm_ack_i = 1'b0;
    check("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("stray_rsp_dat", rsp_dat, 32'd0);
    check("stray_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("stray_cyc", {31'b0, wb.wbm_cyc_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
